alu_cmd_issuer: RTL and testbench

- Sequential front-end that sits directly upstream of the combinational 4-bit ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU as registered operands, captures the 5-bit ALU result, and returns it with an error flag over a second valid/ready handshake.
- Gives the combinational ALU a clocked, back-pressurable wrapper for the rest of the design.

---
 rtl/alu_cmd_issuer.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: clocked, back-pressurable front-end for the combinational
// 4-bit ALU. Commands are buffered in a small FIFO and issued one at a time as
// registered operands. Each ALU result is captured with an error flag and
// returned over a valid/ready response channel.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_opcode,
  input  logic [3:0]    cmd_in1,
  input  logic [3:0]    cmd_in2,
  output logic [3:0]    alu_in1,
  output logic [3:0]    alu_in2,
  output logic [3:0]    alu_opcode,
  input  logic [4:0]    alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [4:0]    rsp_data,
  output logic [3:0]    rsp_opcode,
  output logic          rsp_err,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [11:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [11:0]   head;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          issue_err;

  // Opcodes 0111..1111 are illegal, and a remainder by zero has no
  // meaningful result; both are reported as errors with data 0.
  function automatic logic is_err(input logic [3:0] op, input logic [3:0] in2);
    return (op > 4'd6) || ((op == 4'd3) && (in2 == 4'd0));
  endfunction

  // cmd_ready depends only on the registered count, so a pop in the same
  // cycle never opens the FIFO for a push until the following cycle.
  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = !fifo_empty || (state != IDLE);
  assign issue_err  = is_err(alu_opcode, alu_in2);

  // Next-state logic and pop decision for the issue sequencer.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FIFO storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_opcode, cmd_in1, cmd_in2};
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage 0 -> 1: load the FIFO head into the registered ALU operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= 4'b1111;
    end else if (pop) begin
      alu_opcode <= head[11:8];
      alu_in1    <= head[7:4];
      alu_in2    <= head[3:0];
    end
  end

  // Stage 1 -> 2: capture the ALU result and hold it until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_opcode <= '0;
      rsp_err    <= 1'b0;
    end else if (state == ISSUE) begin
      rsp_valid  <= 1'b1;
      rsp_opcode <= alu_opcode;
      rsp_err    <= issue_err;
      rsp_data   <= issue_err ? 5'd0 : alu_out;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed scenarios followed by randomized
// traffic, checked against a response-queue reference model and a behavioural
// model of the downstream ALU.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0] data;
    logic [3:0] op;
    logic       err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode = '0;
  logic [3:0]    cmd_in1 = '0;
  logic [3:0]    cmd_in2 = '0;
  logic [3:0]    alu_in1;
  logic [3:0]    alu_in2;
  logic [3:0]    alu_opcode;
  logic [4:0]    alu_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [4:0]    rsp_data;
  logic [3:0]    rsp_opcode;
  logic          rsp_err;
  logic          busy;
  logic [CW-1:0] count;

  int   compared   = 0;
  int   mismatched = 0;
  rsp_t exp_q[$];

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; a remainder by zero returns junk that must be masked.
  function automatic logic [4:0] alu_ref(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return p[4:0];
      4'd3:    return (b == 4'd0) ? 5'h1F : {1'b0, a % b};
      4'd4:    return {4'b0, ^{a, b}};
      4'd5:    return {1'b0, a & b};
      4'd6:    return {1'b0, a | b};
      default: return 5'd0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_opcode, alu_in1, alu_in2);

  function automatic rsp_t expect_of(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
    rsp_t r;
    r.op = op;
    if (op > 4'd6 || (op == 4'd3 && b == 4'd0)) begin
      r.data = 5'd0;
      r.err  = 1'b1;
    end else begin
      r.data = alu_ref(op, a, b);
      r.err  = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t cur_rsp();
    rsp_t r;
    r.data = rsp_data;
    r.op   = rsp_opcode;
    r.err  = rsp_err;
    return r;
  endfunction

  // Present one command until accepted; records its expected response.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bit done = 0;
    bit acc;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_in1    = a;
    cmd_in2    = b;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) begin
        exp_q.push_back(expect_of(op, a, b));
        done = 1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 32'(done), 32'd1);
  endtask

  // Wait for the next response, compare it with the model, and accept it.
  task automatic collect(input string tag);
    bit   got = 0;
    rsp_t e;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid) begin
        got = 1;
        if (exp_q.size() == 0) begin
          chk({tag, "_spurious"}, 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(tag, 32'(cur_rsp()), 32'(e));
        end
      end
      tick();
    end
    if (!got) chk({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t held;
    rsp_t cur;
    rsp_t e;
    bit   hold;
    bit   rv;
    bit   cr;
    logic [3:0] op, a, b;

    // Reset values while held in reset
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'hF);
    chk("rst_alu_in", 32'({alu_in1, alu_in2}), 32'd0);
    chk("rst_rsp_fields", 32'(cur_rsp()), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single add 9+8 with latency of two edges after accept
    rsp_ready = 1'b1;
    send(4'd0, 4'd9, 4'd8);
    chk("add_count_after_push", 32'(count), 32'd1);
    chk("add_no_early_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("add_no_valid_n1", 32'(rsp_valid), 32'd0);
    chk("add_alu_ops", 32'({alu_opcode, alu_in1, alu_in2}), 32'h098);
    chk("add_busy", 32'(busy), 32'd1);
    tick();
    chk("add_valid_n2", 32'(rsp_valid), 32'd1);
    chk("add_data", 32'(rsp_data), 32'd17);
    collect("add_rsp");
    chk("add_valid_drop", 32'(rsp_valid), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);

    // Sub then mul back-to-back, responses 2 cycles apart
    send(4'd1, 4'd3, 4'd5);
    send(4'd2, 4'd3, 4'd4);
    tick();
    chk("sub_valid", 32'(rsp_valid), 32'd1);
    chk("sub_data", 32'(rsp_data), 32'h1E);
    collect("sub_rsp");
    chk("gap_valid_low", 32'(rsp_valid), 32'd0);
    tick();
    chk("mul_valid", 32'(rsp_valid), 32'd1);
    chk("mul_data", 32'(rsp_data), 32'd12);
    collect("mul_rsp");

    // Divide by zero, illegal opcode, then a legal remainder
    rsp_ready = 1'b0;
    send(4'd3, 4'd7, 4'd0);
    send(4'b1001, 4'd5, 4'd6);
    send(4'd3, 4'd7, 4'd3);
    collect("div0_rsp");
    collect("illegal_rsp");
    collect("div73_rsp");
    tick();

    // Back-pressure: 1 in flight plus DEPTH buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(4'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    held = cur_rsp();
    chk("full_held_rsp", 32'(held), 32'(exp_q[0]));
    op = 4'd5; a = 4'hC; b = 4'hA;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_in1 = a; cmd_in2 = b;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stable", 32'(cur_rsp()), 32'(held));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_count", 32'(count), 32'(DEPTH));
    end
    // Pop and push presented together while full
    rsp_ready = 1'b1;
    chk("poppush_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    void'(exp_q.pop_front());
    chk("poppush_count", 32'(count), 32'(DEPTH - 1));
    chk("poppush_ready_high", 32'(cmd_ready), 32'd1);
    chk("popush_valid_drop", 32'(rsp_valid), 32'd0);
    exp_q.push_back(expect_of(op, a, b));
    tick();
    cmd_valid = 1'b0;
    chk("popush_refill", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 5; i++) collect("drain_rsp");
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("drain_idle", 32'(busy), 32'd0);

    // Asynchronous reset during RESP with 2 commands queued
    rsp_ready = 1'b0;
    send(4'd0, 4'd1, 4'd2);
    send(4'd1, 4'd4, 4'd2);
    send(4'd6, 4'd1, 4'd8);
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_alu", 32'({alu_opcode, alu_in1, alu_in2}), 32'hF00);
    chk("arst_rsp", 32'(cur_rsp()), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    send(4'd0, 4'd1, 4'd1);
    collect("post_rst_add");

    // Randomized traffic against the response queue
    hold = 0;
    held = '0;
    for (int c = 0; c < 600; c++) begin
      rv  = rsp_valid;
      cr  = cmd_ready;
      cur = cur_rsp();
      if (hold) begin
        chk("rand_hold_valid", 32'(rv), 32'd1);
        chk("rand_hold_data", 32'(cur), 32'(held));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      a  = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      cmd_opcode = op; cmd_in1 = a; cmd_in2 = b;
      if (rv && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", 32'(rv), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_rsp", 32'(cur), 32'(e));
        end
      end
      if (cmd_valid && cr) exp_q.push_back(expect_of(op, a, b));
      hold = rv && !rsp_ready;
      held = cur;
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        chk("rand_drain", 32'(cur_rsp()), 32'(e));
      end
      tick();
    end
    chk("rand_all_returned", 32'(exp_q.size()), 32'd0);
    tick();
    chk("rand_final_valid", 32'(rsp_valid), 32'd0);
    chk("rand_final_busy", 32'(busy), 32'd0);
    chk("rand_final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
